// File: rtl/sync_gen.sv
// sync_gen: programmable video timing generator with per-axis sync polarity (optional composite sync via SYNC_GEN_CSYNC_EN)
module sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          hpol,
  input  logic          vpol,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          frame_start
`ifdef SYNC_GEN_CSYNC_EN
  ,
  output logic          csync
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic          r_hpol;
  logic          r_vpol;
  logic          w_hwrap;
  logic          w_vwrap;
  logic          w_fwrap;
  logic [CW-1:0] w_hn;
  logic [CW-1:0] w_vn;
  logic          w_hp;
  logic          w_vp;
  logic          w_hs;
  logic          w_vs;
  logic          w_hb;
  logic          w_vb;
  // next counter values and decodes, so outputs update on the same edge as the counters
  always_comb begin
    w_hwrap = hcnt == H_LAST;
    w_vwrap = vcnt == V_LAST;
    w_fwrap = w_hwrap & w_vwrap;
    w_hn    = w_hwrap ? '0 : hcnt + 1'b1;
    w_vn    = w_hwrap ? (w_vwrap ? '0 : vcnt + 1'b1) : vcnt;
    w_hp    = w_fwrap ? hpol : r_hpol;
    w_vp    = w_fwrap ? vpol : r_vpol;
    w_hs    = (w_hn >= H_SS) && (w_hn < H_SE);
    w_vs    = (w_vn >= V_SS) && (w_vn < V_SE);
    w_hb    = w_hn >= H_ACT;
    w_vb    = w_vn >= V_ACT;
  end
  // counters, frame-boundary polarity latch and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt        <= '0;
      vcnt        <= '0;
      r_hpol      <= 1'b1;
      r_vpol      <= 1'b1;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      de          <= 1'b1;
      frame_start <= 1'b0;
`ifdef SYNC_GEN_CSYNC_EN
      csync       <= 1'b0;
`endif
    end else begin
      frame_start <= ce_pix & w_fwrap;
      if (ce_pix) begin
        hcnt   <= w_hn;
        vcnt   <= w_vn;
        r_hpol <= w_hp;
        r_vpol <= w_vp;
        hsync  <= w_hp ? w_hs : ~w_hs;
        vsync  <= w_vp ? w_vs : ~w_vs;
        hblank <= w_hb;
        vblank <= w_vb;
        de     <= ~w_hb & ~w_vb;
`ifdef SYNC_GEN_CSYNC_EN
        csync  <= w_hp ? (w_hs ^ w_vs) : ~(w_hs ^ w_vs);
`endif
      end
    end
  end
endmodule

// File: tb/tb_sync_gen.sv
// tb_sync_gen: randomized self-checking bench for sync_gen against a frame-position model
module tb_sync_gen;
  localparam int CW = 12;
  logic          clk = 0;
  logic          reset;
  logic          ce_pix;
  logic          hpol;
  logic          vpol;
  logic          hsync;
  logic          vsync;
  logic          hblank;
  logic          vblank;
  logic          de;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          frame_start;
`ifdef SYNC_GEN_CSYNC_EN
  logic          csync;
`endif
  int total = 0;
  int passed = 0;
  int n;
  logic mhp, mvp, mfs;

  sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .hpol(hpol), .vpol(vpol),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de),
    .hcnt(hcnt), .vcnt(vcnt), .frame_start(frame_start)
`ifdef SYNC_GEN_CSYNC_EN
    , .csync(csync)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
  endtask

  // model: n counts enabled pixels since reset; the 8x6 raster position follows by arithmetic
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0; mhp = 1; mvp = 1; mfs = 0;
    end else begin
      mfs = 0;
      if (ce_pix) begin
        n++;
        if (n % 48 == 0) begin mhp = hpol; mvp = vpol; mfs = 1; end
      end
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      int p, h, v;
      logic hs, vs;
      p = n % 48; h = p % 8; v = p / 8;
      hs = (h == 5 || h == 6);
      vs = (v == 4);
      chk("hcnt", hcnt, h);
      chk("vcnt", vcnt, v);
      chk("hsync", hsync, mhp ? hs : !hs);
      chk("vsync", vsync, mvp ? vs : !vs);
      chk("hblank", hblank, h >= 4);
      chk("vblank", vblank, v >= 3);
      chk("de", de, h < 4 && v < 3);
      chk("frame_start", frame_start, mfs);
`ifdef SYNC_GEN_CSYNC_EN
      chk("csync", csync, mhp ? (hs ^ vs) : !(hs ^ vs));
`endif
    end
  end

  task automatic wait_pos(input int h, input int v);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(hcnt == CW'(h) && vcnt == CW'(v)) && k < 400);
    chk("wait_pos_timeout", k < 400, 1);
  endtask

  initial begin
    int cnt;
    reset = 1; ce_pix = 1; hpol = 1; vpol = 1;
    repeat (2) @(negedge clk);
    chk("rst_hcnt", hcnt, 0);
    chk("rst_vcnt", vcnt, 0);
    chk("rst_hsync", hsync, 0);
    chk("rst_vsync", vsync, 0);
    chk("rst_hblank", hblank, 0);
    chk("rst_de", de, 1);
    chk("rst_fs", frame_start, 0);
    #2 reset = 0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!frame_start && cnt < 200);
    chk("first_frame_start_cycles", cnt, 48);
    wait_pos(5, 0);
    chk("pos_hsync_h5", hsync, 1);
    chk("pos_hblank_h5", hblank, 1);
    chk("pos_de_h5", de, 0);
    wait_pos(0, 4);
    chk("pos_vsync_l4", vsync, 1);
    wait_pos(2, 1);
    hpol = 0; vpol = 0;
    wait_pos(5, 1);
    chk("midframe_still_pos", hsync, 1);
    wait_pos(5, 0);
    chk("neg_hsync_h5", hsync, 0);
    wait_pos(0, 4);
    chk("neg_vsync_l4", vsync, 0);
    chk("neg_hsync_h0", hsync, 1);
    for (int i = 0; i < 288; i++) begin
      ce_pix = (i % 3 == 0);
      @(negedge clk);
    end
    for (int i = 0; i < 1500; i++) begin
      ce_pix = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) hpol = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) vpol = $urandom_range(0, 1);
      @(negedge clk);
    end
    ce_pix = 1; hpol = 0; vpol = 0;
    wait_pos(0, 0);
    wait_pos(6, 4);
    chk("pre_reset_hsync_neg", hsync, 0);
    #2 reset = 1;
    #1;
    chk("async_hcnt", hcnt, 0);
    chk("async_vcnt", vcnt, 0);
    chk("async_hsync", hsync, 0);
    chk("async_vsync", vsync, 0);
    chk("async_de", de, 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("after_reset_hcnt", hcnt, 1);
    for (int i = 0; i < 600; i++) begin
      ce_pix = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) hpol = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) vpol = $urandom_range(0, 1);
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sync_gen.md
# sync_gen

Programmable video timing generator that produces horizontal and vertical sync, blanking and data-enable with a selectable sync polarity per axis. It is the transmit-side counterpart of the sync polarity normaliser: that block accepts sync of either polarity and converts it to a fixed sense, and this block emits sync in whichever polarity the downstream monitor or scaler expects. It sits between the pixel clock domain of a core and the video output path (OSD/scandoubler/DAC).

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- CW, 12, width of the hcnt and vcnt counters

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- ce_pix  in  1  pixel enable; the timing advances only on cycles where it is high
- hpol  in  1  requested hsync polarity: 1 = active-high, 0 = active-low
- vpol  in  1  requested vsync polarity: 1 = active-high, 0 = active-low
- hsync  out  1  horizontal sync, in the latched polarity
- vsync  out  1  vertical sync, in the latched polarity
- hblank  out  1  high outside the active pixels of the line
- vblank  out  1  high outside the active lines of the frame
- de  out  1  data enable: ~hblank & ~vblank
- hcnt  out  CW  current pixel index, 0..H_TOTAL-1
- vcnt  out  CW  current line index, 0..V_TOTAL-1
- frame_start  out  1  one-clk pulse at wrap to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way from the V_* parameters. Both totals must be at most 2^CW. Every segment must be at least 1.
- Line layout: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. The frame layout is identical in lines.
- On a ce_pix cycle, hcnt increments, or wraps to 0 after H_TOTAL-1. On that wrap, vcnt increments, or wraps to 0 after V_TOTAL-1.
- When both counters wrap together, the polarity registers latch hpol and vpol. Polarity therefore changes only at frame boundaries and never mid-frame. frame_start pulses high for exactly one clk cycle, the cycle after that edge.
- hsync = hs_act when the latched hpol is 1, and ~hs_act when it is 0. vsync follows the same rule with vs_act and the latched vpol.
- hs_act is high when hcnt lies in the sync range. vs_act is high when vcnt lies in the vertical sync range. vsync changes only when hcnt = 0.
- hblank is high when hcnt >= H_ACTIVE. vblank is high when vcnt >= V_ACTIVE.
- When ce_pix is low, the counters and all outputs hold their values. The one exception is frame_start, which drops to 0 after its single cycle.
- Toggling hpol or vpol mid-frame has no effect on the outputs until the next (0,0) wrap.

## Timing
- All outputs are registered. hsync, vsync, hblank, vblank and de are always consistent with the hcnt/vcnt values presented in the same clk cycle: there is no skew between the counters and the decodes.
- Decodes are computed from the next counter value, so they update on the same ce_pix edge as the counters.
- Reset values:
  - hcnt=0, vcnt=0
  - latched hpol=1, vpol=1
  - hsync=0, vsync=0, hblank=0, vblank=0
  - de=1, frame_start=0
- The first frame after reset always uses positive polarity. Requested polarity applies from the first wrap onward.
- Reset asserted mid-frame returns everything to the reset values immediately (asynchronously). Counting resumes from (0,0) on the first ce_pix after reset is released.
- The line period is H_TOTAL ce_pix cycles. The frame period is H_TOTAL*V_TOTAL ce_pix cycles.

## Configuration
- SYNC_GEN_CSYNC_EN:
  - Defined: adds an output port csync (1 bit, registered, aligned with hsync). csync_act = hs_act XOR vs_act, which gives inverted (serrated) hsync pulses during vertical sync. csync = csync_act when the latched hpol is 1, and ~csync_act otherwise. Reset value is 0.
  - Undefined: the port and its logic are absent.

## Test plan
All scenarios use H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8), V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6), with ce_pix tied high unless stated.
- Reset, then run: hcnt counts 0..7 and wraps; hsync is high exactly at hcnt=5,6; hblank is high at hcnt=4..7; de is high at hcnt 0..3 only while vcnt is 0..2.
- Full frame: vcnt counts 0..5; vsync is high for all of line 4 (8 cycles); frame_start pulses once every 48 clk cycles, on the cycle after the wrap to (0,0).
- hpol=0 and vpol=0 driven mid-frame 1: outputs stay positive until the 48-cycle wrap, then hsync is low only at hcnt=5,6 and vsync is low only on line 4.
- ce_pix asserted every 3rd clk: all periods stretch ×3; outputs hold between enables; frame_start stays 1 clk wide.
- Reset pulse at (hcnt=6, vcnt=4): hsync, vsync, hcnt and vcnt go to 0 without waiting for a clk edge; the polarity registers return to positive.
- With SYNC_GEN_CSYNC_EN defined: csync is high at hcnt 5,6 on lines 0–3 and 5; on line 4 it is low at hcnt 5,6 and high at every other hcnt.
